divider_quotient_refiner: RTL and testbench
===========================================

// Module: divider_quotient_refiner
// PURPOSE
//  Post-processing stage for the approximate reciprocal-multiply divider: given dividend,
//  divisor and approximate quotient, multiplies back, computes exact remainder, corrects
//  quotient by +/-1 steps until exact. Multi-cycle, valid/ready both sides; sits between
//  approximate divider output and neuron-update datapath consumers needing exact q/r.
// PARAMETERS
//  DVND      32  dividend / quotient width (unsigned)
//  DVSR      32  divisor / remainder width (unsigned)
//  MAX_CORR  3   max correction steps before giving up (>=1)
// PORTS
//  Clock      in   1     system clock, rising edge
//  Reset      in   1     asynchronous, active-high reset
//  in_valid   in   1     request valid
//  in_ready   out  1     block idle, request accepted on in_valid&in_ready
//  dividend   in   DVND  numerator
//  divisor    in   DVSR  denominator
//  approx_q   in   DVND  approximate quotient from divider
//  out_valid  out  1     result valid, held until out_ready
//  out_ready  in   1     consumer accepts result
//  quotient   out  DVND  corrected quotient
//  remainder  out  DVSR  dividend - quotient*divisor
//  corr_count out  clog2(MAX_CORR+1)  correction steps applied
//  corr_fail  out  1     MAX_CORR exhausted; quotient/remainder are last-step values
//  div_zero   out  1     divisor was 0
// BEHAVIOUR
//  Reset: FSM=IDLE, in_ready=1, out_valid=0, all data/flag outputs 0.
//  Inputs latched on acceptance; later input changes ignored until next acceptance.
//  FSM IDLE -> MULT -> CHECK -> DONE -> IDLE.
//  IDLE: in_ready=1. Accept: divisor==0 -> DONE with quotient=all ones, remainder=
//   dividend[DVSR-1:0], div_zero=1, corr_count=0; else load q=approx_q, prod=0 -> MULT.
//  MULT: shift-add, one divisor bit per cycle, exactly DVSR cycles; prod width DVND+DVSR.
//  CHECK: r = {1'b0,dividend} - prod as signed (DVND+DVSR+1 bits), one step per cycle:
//   r<0          -> q=q-1, prod=prod-divisor, count+1
//   r>=divisor   -> q=q+1, prod=prod+divisor, count+1
//   0<=r<divisor -> DONE, remainder=r[DVSR-1:0]
//   step needed with count==MAX_CORR -> DONE, corr_fail=1, remainder=r[DVSR-1:0] (truncated).
//  q arithmetic modulo 2^DVND; for any in-range exact answer no wrap occurs.
//  Latency accept->out_valid: 1 + DVSR + (corr_count+1) cycles; div_zero: 1 cycle.
//  DONE: out_valid=1, outputs stable while out_valid&!out_ready; transfer on
//   out_valid&out_ready -> IDLE, out_valid=0 next cycle. in_ready=0 in MULT/CHECK/DONE;
//   no request accepted in the transfer cycle (one-cycle bubble).
//  Flags cleared on each new acceptance. Reset in any state aborts the operation,
//   no result emitted.
// TESTING
//  100/7, approx_q=14 -> quotient=14, remainder=2, corr_count=0, latency 34 cycles.
//  100/7, approx_q=13 -> quotient=14, remainder=2, corr_count=1, corr_fail=0.
//  100/7, approx_q=16 -> quotient=14, remainder=2, corr_count=2.
//  100/7, approx_q=20 -> corr_fail=1, corr_count=3, quotient=17.
//  divisor=0, dividend=0x1234 -> div_zero=1, quotient=0xFFFFFFFF, remainder=0x1234, 1 cycle.
//  out_ready low 5 cycles in DONE -> outputs stable; Reset mid-MULT -> in_ready=1, out_valid=0.
//  0xFFFFFFFF/1, approx_q=0xFFFFFFFE -> quotient=0xFFFFFFFF, remainder=0, corr_count=1.

Source files
------------

// File: rtl/divider_quotient_refiner.sv
`default_nettype none
// ============================================================================
// Module      : divider_quotient_refiner
// Description : Exact-result stage behind the approximate reciprocal-multiply
//               divider. Latches dividend, divisor and approximate quotient,
//               multiplies quotient*divisor with a bit-serial shift-add, then
//               walks the quotient by +/-1 until the remainder falls in
//               [0, divisor) or MAX_CORR steps have been spent.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready   - request handshake (ready only in IDLE)
//               dividend, divisor, approx_q - request operands
//               out_valid/out_ready - result handshake (held until accepted)
//               quotient, remainder, corr_count, corr_fail, div_zero - result
// Revision    : 1.0 - initial release
// ============================================================================
module divider_quotient_refiner #(
    parameter int DVND     = 32,
    parameter int DVSR     = 32,
    parameter int MAX_CORR = 3
) (
    input  wire logic                            clk,
    input  wire logic                            rst,
    input  wire logic                            in_valid,
    output logic                                 in_ready,
    input  wire logic [DVND-1:0]                 dividend,
    input  wire logic [DVSR-1:0]                 divisor,
    input  wire logic [DVND-1:0]                 approx_q,
    output logic                                 out_valid,
    input  wire logic                            out_ready,
    output logic [DVND-1:0]                      quotient,
    output logic [DVSR-1:0]                      remainder,
    output logic [$clog2(MAX_CORR+1)-1:0]        corr_count,
    output logic                                 corr_fail,
    output logic                                 div_zero
);

    localparam int c_PROD_W = DVND + DVSR;
    localparam int c_RES_W  = c_PROD_W + 1;
    localparam int c_CNT_W  = $clog2(MAX_CORR + 1);
    localparam int c_MCNT_W = $clog2(DVSR + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MULT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q,  state_d;
    logic [DVND-1:0]       dvnd_q,   dvnd_d;
    logic [DVSR-1:0]       dvsr_q,   dvsr_d;
    logic [DVND-1:0]       q_q,      q_d;
    logic [c_PROD_W-1:0]   prod_q,   prod_d;
    logic [c_PROD_W-1:0]   mcand_q,  mcand_d;
    logic [DVSR-1:0]       mplier_q, mplier_d;
    logic [c_MCNT_W-1:0]   mcnt_q,   mcnt_d;
    logic [c_CNT_W-1:0]    cnt_q,    cnt_d;
    logic [DVSR-1:0]       rem_q,    rem_d;
    logic                  fail_q,   fail_d;
    logic                  dz_q,     dz_d;

    logic [c_PROD_W-1:0]   w_dvnd_ext;
    logic [c_PROD_W-1:0]   w_dvsr_ext;
    logic [c_RES_W-1:0]    w_resid;
    logic                  w_neg;
    logic                  w_big;

    // Residual is evaluated one bit wider than the product so that an
    // over-estimated quotient shows up as a negative value.
    assign w_dvnd_ext = {{DVSR{1'b0}}, dvnd_q};
    assign w_dvsr_ext = {{DVND{1'b0}}, dvsr_q};
    assign w_resid    = {1'b0, w_dvnd_ext} - {1'b0, prod_q};
    assign w_neg      = w_resid[c_RES_W-1];
    assign w_big      = !w_neg && (w_resid >= {1'b0, w_dvsr_ext});

    always_comb begin
        state_d  = state_q;
        dvnd_d   = dvnd_q;
        dvsr_d   = dvsr_q;
        q_d      = q_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        mcnt_d   = mcnt_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        fail_d   = fail_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvnd_d = dividend;
                    dvsr_d = divisor;
                    cnt_d  = '0;
                    fail_d = 1'b0;
                    dz_d   = 1'b0;
                    if (divisor == '0) begin
                        q_d     = '1;
                        rem_d   = DVSR'({{DVSR{1'b0}}, dividend});
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        q_d      = approx_q;
                        prod_d   = '0;
                        mcand_d  = {{DVSR{1'b0}}, approx_q};
                        mplier_d = divisor;
                        mcnt_d   = '0;
                        state_d  = S_MULT;
                    end
                end
            end

            // One multiplier bit per cycle, LSB first.
            S_MULT: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                mcnt_d   = mcnt_q + c_MCNT_W'(1);
                if (mcnt_q == c_MCNT_W'(DVSR - 1)) begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (w_neg || w_big) begin
                    if (cnt_q == c_CNT_W'(MAX_CORR)) begin
                        // Out of budget: report the residual as it stands.
                        fail_d  = 1'b1;
                        rem_d   = w_resid[DVSR-1:0];
                        state_d = S_DONE;
                    end else if (w_neg) begin
                        q_d    = q_q - DVND'(1);
                        prod_d = prod_q - w_dvsr_ext;
                        cnt_d  = cnt_q + c_CNT_W'(1);
                    end else begin
                        q_d    = q_q + DVND'(1);
                        prod_d = prod_q + w_dvsr_ext;
                        cnt_d  = cnt_q + c_CNT_W'(1);
                    end
                end else begin
                    rem_d   = w_resid[DVSR-1:0];
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dvnd_q   <= '0;
            dvsr_q   <= '0;
            q_q      <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            mcnt_q   <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            fail_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dvnd_q   <= dvnd_d;
            dvsr_q   <= dvsr_d;
            q_q      <= q_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            mcnt_q   <= mcnt_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            fail_q   <= fail_d;
            dz_q     <= dz_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign quotient   = q_q;
    assign remainder  = rem_q;
    assign corr_count = cnt_q;
    assign corr_fail  = fail_q;
    assign div_zero   = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_quotient_refiner.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_quotient_refiner
// Description : Directed self-checking bench for divider_quotient_refiner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_quotient_refiner;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] approx_q;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [1:0]  corr_count;
    logic        corr_fail;
    logic        div_zero;

    int n_vec;
    int n_err;
    int lat;

    divider_quotient_refiner #(
        .DVND     (32),
        .DVSR     (32),
        .MAX_CORR (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .approx_q   (approx_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .corr_count (corr_count),
        .corr_fail  (corr_fail),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for out_valid. lat counts rising
    // edges from the accept edge (inclusive) to the edge that raises out_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] aq);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        approx_q = aq;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // scramble operands to show they were latched
        dividend = 32'hA5A5_5A5A;
        divisor  = 32'h0000_0000;
        approx_q = 32'h1357_9BDF;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_vec++; if (quotient !== 32'd0)  begin n_err++; $display("FAIL reset_quotient got %h exp 0", quotient); end
        n_vec++; if (remainder !== 32'd0) begin n_err++; $display("FAIL reset_remainder got %h exp 0", remainder); end
        n_vec++; if (corr_count !== 2'd0) begin n_err++; $display("FAIL reset_corr_count got %0d exp 0", corr_count); end
        n_vec++; if (corr_fail !== 1'b0 || div_zero !== 1'b0)
            begin n_err++; $display("FAIL reset_flags got fail=%b dz=%b exp 0 0", corr_fail, div_zero); end
    endtask

    task automatic test_exact();
        run_op(32'd100, 32'd7, 32'd14);
        n_vec++; if (lat !== 34)           begin n_err++; $display("FAIL exact_latency got %0d exp 34", lat); end
        n_vec++; if (quotient !== 32'd14)  begin n_err++; $display("FAIL exact_quotient got %0d exp 14", quotient); end
        n_vec++; if (remainder !== 32'd2)  begin n_err++; $display("FAIL exact_remainder got %0d exp 2", remainder); end
        n_vec++; if (corr_count !== 2'd0)  begin n_err++; $display("FAIL exact_corr_count got %0d exp 0", corr_count); end
        n_vec++; if (in_ready !== 1'b0)    begin n_err++; $display("FAIL exact_in_ready_done got %b exp 0", in_ready); end
        consume();
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL exact_after_xfer got ov=%b ir=%b exp 0 1", out_valid, in_ready); end
    endtask

    task automatic test_under();
        run_op(32'd100, 32'd7, 32'd13);
        n_vec++; if (lat !== 35)           begin n_err++; $display("FAIL under_latency got %0d exp 35", lat); end
        n_vec++; if (quotient !== 32'd14)  begin n_err++; $display("FAIL under_quotient got %0d exp 14", quotient); end
        n_vec++; if (remainder !== 32'd2)  begin n_err++; $display("FAIL under_remainder got %0d exp 2", remainder); end
        n_vec++; if (corr_count !== 2'd1)  begin n_err++; $display("FAIL under_corr_count got %0d exp 1", corr_count); end
        n_vec++; if (corr_fail !== 1'b0)   begin n_err++; $display("FAIL under_corr_fail got %b exp 0", corr_fail); end
        consume();
    endtask

    task automatic test_over();
        run_op(32'd100, 32'd7, 32'd16);
        n_vec++; if (lat !== 36)           begin n_err++; $display("FAIL over_latency got %0d exp 36", lat); end
        n_vec++; if (quotient !== 32'd14)  begin n_err++; $display("FAIL over_quotient got %0d exp 14", quotient); end
        n_vec++; if (remainder !== 32'd2)  begin n_err++; $display("FAIL over_remainder got %0d exp 2", remainder); end
        n_vec++; if (corr_count !== 2'd2)  begin n_err++; $display("FAIL over_corr_count got %0d exp 2", corr_count); end
        consume();
    endtask

    // 100 - 17*7 = -19 -> remainder truncates to 0xFFFFFFED
    task automatic test_corr_fail();
        run_op(32'd100, 32'd7, 32'd20);
        n_vec++; if (lat !== 37)                 begin n_err++; $display("FAIL cfail_latency got %0d exp 37", lat); end
        n_vec++; if (corr_fail !== 1'b1)         begin n_err++; $display("FAIL cfail_flag got %b exp 1", corr_fail); end
        n_vec++; if (corr_count !== 2'd3)        begin n_err++; $display("FAIL cfail_corr_count got %0d exp 3", corr_count); end
        n_vec++; if (quotient !== 32'd17)        begin n_err++; $display("FAIL cfail_quotient got %0d exp 17", quotient); end
        n_vec++; if (remainder !== 32'hFFFF_FFED) begin n_err++; $display("FAIL cfail_remainder got %h exp ffffffed", remainder); end
        n_vec++; if (div_zero !== 1'b0)          begin n_err++; $display("FAIL cfail_div_zero got %b exp 0", div_zero); end
        consume();
    endtask

    task automatic test_div_zero();
        run_op(32'h0000_1234, 32'd0, 32'd55);
        n_vec++; if (lat !== 1)                  begin n_err++; $display("FAIL dz_latency got %0d exp 1", lat); end
        n_vec++; if (div_zero !== 1'b1)          begin n_err++; $display("FAIL dz_flag got %b exp 1", div_zero); end
        n_vec++; if (quotient !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dz_quotient got %h exp ffffffff", quotient); end
        n_vec++; if (remainder !== 32'h0000_1234) begin n_err++; $display("FAIL dz_remainder got %h exp 1234", remainder); end
        n_vec++; if (corr_count !== 2'd0)        begin n_err++; $display("FAIL dz_corr_count got %0d exp 0", corr_count); end
        n_vec++; if (corr_fail !== 1'b0)         begin n_err++; $display("FAIL dz_corr_fail_cleared got %b exp 0", corr_fail); end
        consume();
    endtask

    task automatic test_hold();
        run_op(32'd100, 32'd7, 32'd13);
        out_ready = 1'b0;
        // a competing request during DONE must be ignored
        in_valid  = 1'b1;
        dividend  = 32'd999;
        divisor   = 32'd3;
        approx_q  = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd14 ||
                remainder !== 32'd2 || corr_count !== 2'd1) begin
                n_err++;
                $display("FAIL hold_cycle%0d got ov=%b ir=%b q=%0d r=%0d c=%0d exp 1 0 14 2 1",
                         i, out_valid, in_ready, quotient, remainder, corr_count);
            end
        end
        in_valid = 1'b0;
        consume();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        approx_q = 32'd14;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b exp 0", in_ready); end
        rst = 1'b1;
        #2;
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin n_err++; $display("FAIL rmid_async got ir=%b ov=%b exp 1 0", in_ready, out_valid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL rmid_no_result got ov=%b ir=%b exp 0 1", out_valid, in_ready); end
    endtask

    task automatic test_max_wrap();
        run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE);
        n_vec++; if (lat !== 35)                 begin n_err++; $display("FAIL max_latency got %0d exp 35", lat); end
        n_vec++; if (quotient !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL max_quotient got %h exp ffffffff", quotient); end
        n_vec++; if (remainder !== 32'd0)        begin n_err++; $display("FAIL max_remainder got %h exp 0", remainder); end
        n_vec++; if (corr_count !== 2'd1)        begin n_err++; $display("FAIL max_corr_count got %0d exp 1", corr_count); end
        consume();
    endtask

    // 0xDEADBEEF = 3735928559 = 801701*4660 + 1899 ; 1000 = 30*33 + 10
    task automatic test_back_to_back();
        run_op(32'hDEAD_BEEF, 32'h0000_1234, 32'd801700);
        n_vec++; if (quotient !== 32'd801701 || remainder !== 32'd1899 || corr_count !== 2'd1 || lat !== 35)
            begin n_err++; $display("FAIL b2b_first got q=%0d r=%0d c=%0d lat=%0d exp 801701 1899 1 35",
                                    quotient, remainder, corr_count, lat); end
        consume();
        run_op(32'd1000, 32'd33, 32'd30);
        n_vec++; if (quotient !== 32'd30 || remainder !== 32'd10 || corr_count !== 2'd0 || lat !== 34)
            begin n_err++; $display("FAIL b2b_second got q=%0d r=%0d c=%0d lat=%0d exp 30 10 0 34",
                                    quotient, remainder, corr_count, lat); end
        consume();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        lat       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        approx_q  = '0;

        test_reset();
        test_exact();
        test_under();
        test_over();
        test_corr_fail();
        test_div_zero();
        test_hold();
        test_reset_mid();
        test_max_wrap();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
